// File: rtl/sfx_event_scheduler.sv
// Queues good/bad/best jingle requests and plays them one at a time with a silent gap; best preempts good/bad.
// 2-cycle request-to-play latency from idle; no backpressure: losing or overflowing requests are dropped and counted.
module sfx_event_scheduler #(
    parameter int PLAY_CYCLES = 550_000_000,
    parameter int GAP_CYCLES  = 10_000_000,
    parameter int QUEUE_DEPTH = 4,
    parameter int TIMER_W     = 30
) (
    input  logic                         clk,
    input  logic                         rst_one_pulsed,
    input  logic                         req_good_i,
    input  logic                         req_bad_i,
    input  logic                         req_best_i,
    input  logic                         flush_i,
    output logic [1:0]                   sfx_state_o,
    output logic                         duck_o,
    output logic                         sfx_done_o,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count_o,
    output logic [7:0]                   drop_count_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TIMER_W-1:0] PLAY_LAST = TIMER_W'(PLAY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] CODE_SIL  = 2'b00;
    localparam logic [1:0] CODE_GOOD = 2'b01;
    localparam logic [1:0] CODE_BAD  = 2'b10;
    localparam logic [1:0] CODE_BEST = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         sfx_state_q, sfx_state_d;
    logic               duck_q, duck_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         drop_q, drop_d;
    logic [1:0]         mem_q [QUEUE_DEPTH];

    logic       win_vld;
    logic [1:0] win_code;
    logic [1:0] n_req;
    logic [1:0] losers;
    logic       play_end, gap_end;
    logic       q_empty, q_full;
    logic       preempt, pop, push_try, push, full_drop;
    logic [1:0] head;
    logic [8:0] drop_sum;

    assign win_vld  = req_best_i | req_good_i | req_bad_i;
    assign win_code = req_best_i ? CODE_BEST : (req_good_i ? CODE_GOOD : CODE_BAD);
    assign n_req    = {1'b0, req_best_i} + {1'b0, req_good_i} + {1'b0, req_bad_i};
    assign losers   = (win_vld && !flush_i) ? (n_req - 2'd1) : 2'd0;

    assign play_end = (state_q == S_PLAY) && (timer_q == PLAY_LAST);
    assign gap_end  = (state_q == S_GAP)  && (timer_q == GAP_LAST);
    assign q_empty  = (count_q == '0);
    assign q_full   = (count_q == CNT_FULL);
    assign head     = mem_q[rd_ptr_q];

    // Preemption wins over a coincident end-of-play: the best jingle restarts the timer.
    assign preempt   = !flush_i && req_best_i && (state_q == S_PLAY) &&
                       ((sfx_state_q == CODE_GOOD) || (sfx_state_q == CODE_BAD));
    assign pop       = !flush_i && !q_empty && ((state_q == S_IDLE) || gap_end);
    assign push_try  = !flush_i && win_vld && !preempt;
    assign push      = push_try && (!q_full || pop);
    assign full_drop = push_try && !push;

    assign drop_sum = {1'b0, drop_q} + {7'd0, losers} + {8'd0, full_drop};
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    assign count_d  = flush_i ? '0 : (count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop});
    assign wr_ptr_d = flush_i ? '0 : (push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q);
    assign rd_ptr_d = flush_i ? '0 : (pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q);

    always_ff @(posedge clk or posedge rst_one_pulsed) begin
        if (rst_one_pulsed) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (pop) state_d = S_PLAY;
                S_PLAY:  if (!preempt && play_end) state_d = S_GAP;
                S_GAP:   if (gap_end) state_d = pop ? S_PLAY : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        timer_d     = timer_q;
        sfx_state_d = sfx_state_q;
        duck_d      = duck_q;
        done_d      = 1'b0;
        if (flush_i) begin
            timer_d     = '0;
            sfx_state_d = CODE_SIL;
            duck_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        sfx_state_d = head;
                        duck_d      = 1'b1;
                        timer_d     = '0;
                    end
                end
                S_PLAY: begin
                    if (preempt) begin
                        sfx_state_d = CODE_BEST;
                        timer_d     = '0;
                    end else if (play_end) begin
                        sfx_state_d = CODE_SIL;
                        duck_d      = 1'b0;
                        done_d      = 1'b1;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        timer_d = '0;
                        if (pop) begin
                            sfx_state_d = head;
                            duck_d      = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: begin
                    timer_d     = '0;
                    sfx_state_d = CODE_SIL;
                    duck_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_one_pulsed) begin
        if (rst_one_pulsed) begin
            timer_q     <= '0;
            sfx_state_q <= CODE_SIL;
            duck_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            drop_q      <= '0;
        end else begin
            timer_q     <= timer_d;
            sfx_state_q <= sfx_state_d;
            duck_q      <= duck_d;
            done_q      <= done_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= win_code;
        end
    end

    assign sfx_state_o   = sfx_state_q;
    assign duck_o        = duck_q;
    assign sfx_done_o    = done_q;
    assign queue_count_o = count_q;
    assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_sfx_event_scheduler.sv
// Bench for sfx_event_scheduler: cycle tables, hand-built corner sequences, and a
// randomized run against a queue/countdown reference model.
module tb_sfx_event_scheduler;

    localparam int PLAY  = 8;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_good = 1'b0, req_bad = 1'b0, req_best = 1'b0, flush = 1'b0;
    logic [1:0] sfx_state;
    logic       duck, sfx_done;
    logic [2:0] queue_count;
    logic [7:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sfx_event_scheduler #(
        .PLAY_CYCLES(PLAY),
        .GAP_CYCLES (GAP),
        .QUEUE_DEPTH(DEPTH),
        .TIMER_W    (8)
    ) dut (
        .clk           (clk),
        .rst_one_pulsed(rst),
        .req_good_i    (req_good),
        .req_bad_i     (req_bad),
        .req_best_i    (req_best),
        .flush_i       (flush),
        .sfx_state_o   (sfx_state),
        .duck_o        (duck),
        .sfx_done_o    (sfx_done),
        .queue_count_o (queue_count),
        .drop_count_o  (drop_count)
    );

    typedef struct {
        logic [3:0] in;     // {flush, best, bad, good}
        logic [1:0] sfx;
        logic       duck;
        logic       done;
        logic [2:0] qc;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs[$];

    // Reference model: pending queue plus countdowns of remaining play / gap cycles.
    int   mq[$];
    int   m_play = 0;
    int   m_left = 0;
    int   m_gap  = 0;
    int   m_drop = 0;
    logic m_done = 1'b0;

    function automatic logic [14:0] pk(input logic [1:0] s, input logic d, input logic dn,
                                       input logic [2:0] q, input logic [7:0] dr);
        return {s, d, dn, q, dr};
    endfunction

    function automatic logic [14:0] dut_pk();
        return pk(sfx_state, duck, sfx_done, queue_count, drop_count);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {flush, req_best, req_bad, req_good} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic [3:0] in, input logic [1:0] s, input logic d,
                       input logic dn, input logic [2:0] q, input logic [7:0] dr);
        vec_t v;
        v.in = in; v.sfx = s; v.duck = d; v.done = dn; v.qc = q; v.drop = dr;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic model_step(input logic ig, input logic ib, input logic ibst, input logic ifl);
        int  nreq, win, head;
        bit  preempt, pop, idle;
        m_done = 1'b0;
        if (ifl) begin
            mq.delete();
            m_play = 0; m_left = 0; m_gap = 0;
            return;
        end
        nreq = int'(ig) + int'(ib) + int'(ibst);
        win  = ibst ? 3 : (ig ? 1 : (ib ? 2 : 0));
        if (nreq > 1) m_drop += nreq - 1;
        preempt = ibst && (m_play == 1 || m_play == 2);
        idle    = (m_play == 0) && (m_gap == 0);
        pop     = (mq.size() > 0) && (idle || m_gap == 1);
        head    = 0;
        if (pop) head = mq.pop_front();
        if (nreq > 0 && !preempt) begin
            if (mq.size() < DEPTH) mq.push_back(win);
            else m_drop++;
        end
        if (m_drop > 255) m_drop = 255;
        if (preempt) begin
            m_play = 3; m_left = PLAY;
        end else if (m_play != 0) begin
            if (m_left == 1) begin
                m_play = 0; m_done = 1'b1; m_gap = GAP;
            end else begin
                m_left--;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else if (pop) begin
            m_play = head; m_left = PLAY; m_gap = 0;
        end else begin
            m_gap = 0;
        end
    endtask

    initial begin
        // Single good jingle.
        add(1, 4'b0001, 2'd0, 0, 0, 3'd0, 8'd0);
        add(1, 4'b0000, 2'd0, 0, 0, 3'd1, 8'd0);
        add(8, 4'b0000, 2'd1, 1, 0, 3'd0, 8'd0);
        add(1, 4'b0000, 2'd0, 0, 1, 3'd0, 8'd0);
        add(2, 4'b0000, 2'd0, 0, 0, 3'd0, 8'd0);
        // Back-to-back bad then good.
        add(1, 4'b0010, 2'd0, 0, 0, 3'd0, 8'd0);
        add(1, 4'b0001, 2'd0, 0, 0, 3'd1, 8'd0);
        add(8, 4'b0000, 2'd2, 1, 0, 3'd1, 8'd0);
        add(1, 4'b0000, 2'd0, 0, 1, 3'd1, 8'd0);
        add(1, 4'b0000, 2'd0, 0, 0, 3'd1, 8'd0);
        add(8, 4'b0000, 2'd1, 1, 0, 3'd0, 8'd0);
        add(1, 4'b0000, 2'd0, 0, 1, 3'd0, 8'd0);
        add(2, 4'b0000, 2'd0, 0, 0, 3'd0, 8'd0);
        // Good+bad together, then best preempts in play cycle 5.
        add(1, 4'b0011, 2'd0, 0, 0, 3'd0, 8'd0);
        add(1, 4'b0000, 2'd0, 0, 0, 3'd1, 8'd1);
        add(5, 4'b0000, 2'd1, 1, 0, 3'd0, 8'd1);
        add(1, 4'b0100, 2'd1, 1, 0, 3'd0, 8'd1);
        add(8, 4'b0000, 2'd3, 1, 0, 3'd0, 8'd1);
        add(1, 4'b0000, 2'd0, 0, 1, 3'd0, 8'd1);
        add(2, 4'b0000, 2'd0, 0, 0, 3'd0, 8'd1);

        repeat (2) tick();
        check("reset_state", 32'(dut_pk()), 32'(pk(2'd0, 0, 0, 3'd0, 8'd0)));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            check($sformatf("vec%0d", i), 32'(dut_pk()),
                  32'(pk(vecs[i].sfx, vecs[i].duck, vecs[i].done, vecs[i].qc, vecs[i].drop)));
            tick();
        end
        drive(4'b0000);

        // Overflow: one playing, six more goods, queue holds four, two dropped.
        for (int c = 0; c < 54; c++) begin
            drive((c == 0 || (c >= 3 && c <= 8)) ? 4'b0001 : 4'b0000);
            check($sformatf("ovf_sfx_c%0d", c), 32'(sfx_state),
                  (c >= 2 && c <= 49 && ((c - 2) % 10) < 8) ? 32'd1 : 32'd0);
            if (c == 9) begin
                check("ovf_qc_full", 32'(queue_count), 32'd4);
                check("ovf_drop", 32'(drop_count), 32'd3);
            end
            if (c == 12) check("ovf_qc_after_pop", 32'(queue_count), 32'd3);
            if (c == 50) check("ovf_last_done", 32'(sfx_done), 32'd1);
            tick();
        end
        drive(4'b0000);

        // Flush during play with three queued; simultaneous good ignored.
        for (int c = 0; c < 13; c++) begin
            case (c)
                0, 4:    drive(4'b0001);
                3, 5:    drive(4'b0010);
                6:       drive(4'b1001);
                default: drive(4'b0000);
            endcase
            if (c == 6) check("flush_pre", 32'(dut_pk()), 32'(pk(2'd1, 1, 0, 3'd3, 8'd3)));
            if (c >= 7) check($sformatf("flush_c%0d", c), 32'(dut_pk()),
                              32'(pk(2'd0, 0, 0, 3'd0, 8'd3)));
            tick();
        end
        drive(4'b0000);

        // Asynchronous reset in the gap with two queued.
        for (int c = 0; c < 10; c++) begin
            drive((c == 0 || c == 4) ? 4'b0001 : (c == 3 ? 4'b0010 : 4'b0000));
            tick();
        end
        drive(4'b0000);
        check("rst_gap_pre", 32'(dut_pk()), 32'(pk(2'd0, 0, 1, 3'd2, 8'd3)));
        #3 rst = 1'b1;
        #1 check("rst_async", 32'(dut_pk()), 32'(pk(2'd0, 0, 0, 3'd0, 8'd0)));
        #2 rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            check($sformatf("rst_quiet_c%0d", c), 32'(dut_pk()), 32'(pk(2'd0, 0, 0, 3'd0, 8'd0)));
        end
        drive(4'b0001);
        tick();
        drive(4'b0000);
        check("rst_new_req_q", 32'(dut_pk()), 32'(pk(2'd0, 0, 0, 3'd1, 8'd0)));
        tick();
        check("rst_new_req_play", 32'(dut_pk()), 32'(pk(2'd1, 1, 0, 3'd0, 8'd0)));

        // Randomized run against the reference model.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        m_play = 0; m_left = 0; m_gap = 0; m_drop = 0; m_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic ig, ib, ibst, ifl;
            ifl  = ($urandom_range(0, 49) == 0);
            ig   = ($urandom_range(0, 3) == 0);
            ib   = ($urandom_range(0, 3) == 0);
            ibst = ($urandom_range(0, 7) == 0);
            drive({ifl, ibst, ib, ig});
            check($sformatf("rand_c%0d", c), 32'(dut_pk()),
                  32'(pk(2'(m_play), m_play != 0, m_done, 3'(mq.size()), 8'(m_drop))));
            model_step(ig, ib, ibst, ifl);
            tick();
        end
        drive(4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
